// File: rtl/ws2812b_chain_node.sv
// ws2812b_chain_node: one node of a WS2812B-style LED chain.
// Assembles decoded bits into bytes and captures the first NUM_PIXELS
// pixels of BYTES_PER_PIXEL bytes each, muting dout meanwhile. Once full, it
// forwards the raw DIN waveform downstream until the reset/idle code arrives.
//
// Optional feature macro: WS2812_LATCH_EN. When defined, captured bytes fill a
// shadow buffer that is copied to pixel_data on frame_done (latch-on-reset).
// When undefined, pixel_data is the live capture buffer.
//
// Ports:
//   clk, reset      system clock, synchronous active-high reset
//   din_raw         synchronised DIN waveform (forwarded in FORWARD)
//   bit_valid       one-cycle pulse, decoded bit available on bit_value
//   bit_value       decoded bit value
//   idle            level, high while the reset/idle code is detected
//   dout            registered downstream waveform
//   pixel_data      displayed colour data, byte slot k at [k*8+7:k*8]
//   pixel_valid     pulse when a pixel's last byte is captured
//   pixel_index     index of the pixel reported by pixel_valid
//   frame_done      pulse on first idle cycle after a captured pixel
//   forwarding      high in FORWARD state
module ws2812b_chain_node #(
  parameter int unsigned BYTES_PER_PIXEL = 3,
  parameter int unsigned NUM_PIXELS      = 1,
  localparam int unsigned IDX_W          = (NUM_PIXELS > 1) ? $clog2(NUM_PIXELS) : 1
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     din_raw,
  input  logic                                     bit_valid,
  input  logic                                     bit_value,
  input  logic                                     idle,
  output logic                                     dout,
  output logic [NUM_PIXELS*BYTES_PER_PIXEL*8-1:0]  pixel_data,
  output logic                                     pixel_valid,
  output logic [IDX_W-1:0]                         pixel_index,
  output logic                                     frame_done,
  output logic                                     forwarding
);

  localparam int unsigned SLOTS  = NUM_PIXELS * BYTES_PER_PIXEL;
  localparam int unsigned DATA_W = SLOTS * 8;
  localparam int unsigned BYTE_W = (BYTES_PER_PIXEL > 1) ? $clog2(BYTES_PER_PIXEL) : 1;
  localparam int unsigned SLOT_W = (SLOTS > 1) ? $clog2(SLOTS) : 1;

  localparam logic [BYTE_W-1:0] LAST_BYTE = BYTE_W'(BYTES_PER_PIXEL - 1);
  localparam logic [IDX_W-1:0]  LAST_PIX  = IDX_W'(NUM_PIXELS - 1);

  typedef enum logic {
    ST_CAPTURE = 1'b0,
    ST_FORWARD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic [2:0]          bit_cnt_q, bit_cnt_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [IDX_W-1:0]    pix_cnt_q, pix_cnt_d;
  // Only 7 bits are stored: the 8th bit of a byte is taken straight from bit_value.
  logic [6:0]          shift_q, shift_d;
  logic [DATA_W-1:0]   cap_q, cap_d;
  logic                dout_q, dout_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [IDX_W-1:0]    pixel_index_q, pixel_index_d;
  logic                frame_done_q, frame_done_d;
  logic                seen_q, seen_d;        // a pixel completed since last frame_done
  logic                idle_prev_q, idle_prev_d;
`ifdef WS2812_LATCH_EN
  logic [DATA_W-1:0]   disp_q, disp_d;
`endif

  logic [7:0]          new_byte;
  logic [SLOT_W-1:0]   slot;

  // Next-state, capture and output logic.
  always_comb begin
    state_d       = state_q;
    bit_cnt_d     = bit_cnt_q;
    byte_cnt_d    = byte_cnt_q;
    pix_cnt_d     = pix_cnt_q;
    shift_d       = shift_q;
    cap_d         = cap_q;
    pixel_valid_d = 1'b0;
    pixel_index_d = pixel_index_q;
    frame_done_d  = 1'b0;
    seen_d        = seen_q;
    idle_prev_d   = idle;
    dout_d        = (state_q == ST_FORWARD) ? din_raw : 1'b0;
`ifdef WS2812_LATCH_EN
    disp_d        = disp_q;
`endif

    new_byte = {shift_q, bit_value};
    slot     = SLOT_W'(32'(pix_cnt_q) * BYTES_PER_PIXEL + 32'(byte_cnt_q));

    if (idle) begin
      // Idle wins over any coincident bit; partial bytes are discarded.
      state_d    = ST_CAPTURE;
      bit_cnt_d  = 3'd0;
      byte_cnt_d = '0;
      pix_cnt_d  = '0;
      shift_d    = '0;
      if (!idle_prev_q && seen_q) begin
        frame_done_d = 1'b1;
        seen_d       = 1'b0;
`ifdef WS2812_LATCH_EN
        disp_d       = cap_q;
`endif
      end
    end else if (state_q == ST_CAPTURE && bit_valid) begin
      shift_d   = new_byte[6:0];
      bit_cnt_d = bit_cnt_q + 3'd1;
      if (bit_cnt_q == 3'd7) begin
        for (int unsigned k = 0; k < SLOTS; k++) begin
          if (slot == SLOT_W'(k)) cap_d[k*8 +: 8] = new_byte;
        end
        if (byte_cnt_q == LAST_BYTE) begin
          pixel_valid_d = 1'b1;
          pixel_index_d = pix_cnt_q;
          seen_d        = 1'b1;
          byte_cnt_d    = '0;
          if (pix_cnt_q == LAST_PIX) begin
            state_d   = ST_FORWARD;
            pix_cnt_d = '0;
          end else begin
            pix_cnt_d = pix_cnt_q + IDX_W'(1);
          end
        end else begin
          byte_cnt_d = byte_cnt_q + BYTE_W'(1);
        end
      end
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_CAPTURE;
      bit_cnt_q     <= 3'd0;
      byte_cnt_q    <= '0;
      pix_cnt_q     <= '0;
      shift_q       <= '0;
      cap_q         <= '0;
      dout_q        <= 1'b0;
      pixel_valid_q <= 1'b0;
      pixel_index_q <= '0;
      frame_done_q  <= 1'b0;
      seen_q        <= 1'b0;
      idle_prev_q   <= 1'b0;
`ifdef WS2812_LATCH_EN
      disp_q        <= '0;
`endif
    end else begin
      state_q       <= state_d;
      bit_cnt_q     <= bit_cnt_d;
      byte_cnt_q    <= byte_cnt_d;
      pix_cnt_q     <= pix_cnt_d;
      shift_q       <= shift_d;
      cap_q         <= cap_d;
      dout_q        <= dout_d;
      pixel_valid_q <= pixel_valid_d;
      pixel_index_q <= pixel_index_d;
      frame_done_q  <= frame_done_d;
      seen_q        <= seen_d;
      idle_prev_q   <= idle_prev_d;
`ifdef WS2812_LATCH_EN
      disp_q        <= disp_d;
`endif
    end
  end

  assign dout        = dout_q;
  assign pixel_valid = pixel_valid_q;
  assign pixel_index = pixel_index_q;
  assign frame_done  = frame_done_q;
  assign forwarding  = (state_q == ST_FORWARD);
`ifdef WS2812_LATCH_EN
  assign pixel_data  = disp_q;
`else
  assign pixel_data  = cap_q;
`endif

endmodule

// File: tb/tb_ws2812b_chain_node.sv
// Randomised scoreboard bench for ws2812b_chain_node (2 pixels x 3 bytes).
module tb_ws2812b_chain_node;

  localparam int unsigned BPP        = 3;
  localparam int unsigned NP         = 2;
  localparam int unsigned SLOTS      = BPP * NP;
  localparam int unsigned DW         = SLOTS * 8;
  localparam int unsigned FRAME_BITS = SLOTS * 8;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          din_raw = 1'b0;
  logic          bit_valid = 1'b0;
  logic          bit_value = 1'b0;
  logic          idle = 1'b0;
  logic          dout;
  logic [DW-1:0] pixel_data;
  logic          pixel_valid;
  logic [0:0]    pixel_index;
  logic          frame_done;
  logic          forwarding;

  always #5 clk = ~clk;

  ws2812b_chain_node #(.BYTES_PER_PIXEL(BPP), .NUM_PIXELS(NP)) dut (
    .clk        (clk),
    .reset      (reset),
    .din_raw    (din_raw),
    .bit_valid  (bit_valid),
    .bit_value  (bit_value),
    .idle       (idle),
    .dout       (dout),
    .pixel_data (pixel_data),
    .pixel_valid(pixel_valid),
    .pixel_index(pixel_index),
    .frame_done (frame_done),
    .forwarding (forwarding)
  );

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  bit mon_en = 1'b0;

  // Reference model: frame-level view (bits accepted so far, byte buffers).
  logic [7:0]    cap_m  [SLOTS];
  logic [7:0]    disp_m [SLOTS];
  int            nb = 0;
  logic [7:0]    acc = '0;
  logic          m_fwd = 1'b0;
  logic          m_seen = 1'b0;
  logic          m_idle_prev = 1'b0;
  logic          m_dout_next = 1'b0;
  logic [DW-1:0] m_pd = '0;

  logic          exp_fwd_cur = 1'b0;
  logic          exp_dout_cur = 1'b0;
  logic [DW-1:0] exp_pd_cur = '0;

  typedef struct { int idx; int cyc; } pv_t;
  pv_t pv_q[$];
  int  fd_q[$];

  initial begin
    for (int k = 0; k < SLOTS; k++) begin
      cap_m[k]  = 8'h00;
      disp_m[k] = 8'h00;
    end
  end

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  always @(posedge clk) cyc <= cyc + 1;

  // Model expectations become visible on the edge after they are computed.
  always @(posedge clk) begin
    exp_fwd_cur  <= m_fwd;
    exp_dout_cur <= m_dout_next;
    exp_pd_cur   <= m_pd;
  end

  // Drive one cycle of inputs and advance the reference model for that cycle.
  task automatic step(input bit r, input bit bv, input bit b, input bit idl, input bit d);
    @(posedge clk);
    #1;
    reset = r; bit_valid = bv; bit_value = b; idle = idl; din_raw = d;
    m_dout_next = (!r && m_fwd) ? d : 1'b0;
    if (r) begin
      for (int k = 0; k < SLOTS; k++) begin
        cap_m[k]  = 8'h00;
        disp_m[k] = 8'h00;
      end
      nb = 0; acc = '0; m_fwd = 1'b0; m_seen = 1'b0;
    end else if (idl) begin
      if (!m_idle_prev && m_seen) begin
        fd_q.push_back(cyc + 1);
`ifdef WS2812_LATCH_EN
        for (int k = 0; k < SLOTS; k++) disp_m[k] = cap_m[k];
`endif
        m_seen = 1'b0;
      end
      nb = 0; acc = '0; m_fwd = 1'b0;
    end else if (bv && !m_fwd) begin
      acc = {acc[6:0], b};
      nb++;
      if (nb % 8 == 0) begin
        cap_m[nb/8 - 1] = acc;
        if ((nb/8) % BPP == 0) begin
          pv_q.push_back('{idx: (nb/8)/BPP - 1, cyc: cyc + 1});
          m_seen = 1'b1;
        end
        if (nb == FRAME_BITS) m_fwd = 1'b1;
      end
    end
    m_idle_prev = r ? 1'b0 : idl;
    for (int k = 0; k < SLOTS; k++) begin
`ifdef WS2812_LATCH_EN
      m_pd[k*8 +: 8] = disp_m[k];
`else
      m_pd[k*8 +: 8] = cap_m[k];
`endif
    end
  endtask

  task automatic send_bit(input bit b, input int max_gap);
    int gap;
    gap = int'($urandom_range(32'(max_gap), 0));
    repeat (gap) step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
    step(1'b0, 1'b1, b, 1'b0, 1'($urandom));
  endtask

  task automatic send_byte(input logic [7:0] v, input int max_gap);
    for (int i = 7; i >= 0; i--) send_bit(v[i], max_gap);
  endtask

  task automatic idle_for(input int n);
    repeat (n) step(1'b0, 1'b0, 1'b0, 1'b1, 1'($urandom));
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'($urandom));
  endtask

  // Monitor: per-cycle outputs and pulse events against the scoreboard.
  always @(negedge clk) begin
    if (mon_en) begin
      pv_t e;
      int  fc;
      check("forwarding", DW'(forwarding), DW'(exp_fwd_cur));
      check("dout", DW'(dout), DW'(exp_dout_cur));
      check("pixel_data", pixel_data, exp_pd_cur);
      if (pixel_valid) begin
        if (pv_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL pixel_valid_unexpected at cycle %0d: got 1 expected 0", cyc);
        end else begin
          e = pv_q.pop_front();
          check("pixel_valid_cycle", DW'(cyc), DW'(e.cyc));
          check("pixel_index", DW'(pixel_index), DW'(e.idx));
        end
      end else if (pv_q.size() > 0 && pv_q[0].cyc <= cyc) begin
        checks++; errors++;
        $display("FAIL pixel_valid_missing at cycle %0d: got 0 expected 1", cyc);
        void'(pv_q.pop_front());
      end
      if (frame_done) begin
        if (fd_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL frame_done_unexpected at cycle %0d: got 1 expected 0", cyc);
        end else begin
          fc = fd_q.pop_front();
          check("frame_done_cycle", DW'(cyc), DW'(fc));
        end
      end else if (fd_q.size() > 0 && fd_q[0] <= cyc) begin
        checks++; errors++;
        $display("FAIL frame_done_missing at cycle %0d: got 0 expected 1", cyc);
        void'(fd_q.pop_front());
      end
    end
  end

  initial begin
    int nbits;
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    mon_en = 1'b1;
    check("reset_pixel_valid", DW'(pixel_valid), '0);
    check("reset_frame_done", DW'(frame_done), '0);
    check("reset_pixel_index", DW'(pixel_index), '0);
    check("reset_pixel_data", pixel_data, '0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Two full pixels, back-to-back then gapped, followed by forwarded bits.
    send_byte(8'h12, 0); send_byte(8'h34, 0); send_byte(8'h56, 0);
    send_byte(8'hAA, 2); send_byte(8'hBB, 2); send_byte(8'hCC, 2);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("forwarding_after_frame", DW'(forwarding), DW'(1));
    send_byte(8'($urandom), 1);
    idle_for(3);
    check("pixel_data_frame1", pixel_data, 48'hCCBBAA563412);

    // Partial pixel then idle: no pixel event or frame_done.
    repeat (13) send_bit(1'($urandom), 1);
    idle_for(2);
    for (int i = 1; i <= 6; i++) send_byte(8'(i), 1);
    idle_for(2);
    check("pixel_data_after_partial", pixel_data, 48'h060504030201);

    // Bit coincident with the first idle cycle is dropped.
    repeat (10) send_bit(1'($urandom), 0);
    step(1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    idle_for(2);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
    idle_for(1);

    // Reset while forwarding.
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 0);
    repeat (5) send_bit(1'($urandom), 0);
    step(1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    check("reset_fwd_forwarding", DW'(forwarding), '0);
    check("reset_fwd_pixel_data", pixel_data, '0);
    for (int i = 0; i < 6; i++) send_byte(8'($urandom), 1);
    idle_for(2);

    // Latch behaviour: first byte mid-second-frame.
    send_byte(8'hAA, 0); send_byte(8'hBB, 0); send_byte(8'hCC, 0);
    send_byte(8'hDD, 0); send_byte(8'hEE, 0); send_byte(8'hFF, 0);
    idle_for(2);
    send_byte(8'h11, 0); send_byte(8'h22, 0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
`ifdef WS2812_LATCH_EN
    check("latch_mid_frame_byte0", DW'(pixel_data[7:0]), DW'(8'hAA));
`else
    check("live_mid_frame_byte0", DW'(pixel_data[7:0]), DW'(8'h11));
`endif
    send_byte(8'h33, 0);
    idle_for(2);

    // Randomised frames with gaps, coincident idles and occasional reset.
    for (int it = 0; it < 25; it++) begin
      nbits = int'($urandom_range(70, 0));
      for (int i = 0; i < nbits; i++) send_bit(1'($urandom), 2);
      case ($urandom_range(3, 0))
        0: step(1'b0, 1'b1, 1'($urandom), 1'b1, 1'($urandom));
        1: step(1'b1, 1'b0, 1'b0, 1'b0, 1'($urandom));
        default: ;
      endcase
      idle_for(int'($urandom_range(3, 1)));
    end

    repeat (3) step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    check("pixel_events_drained", DW'(pv_q.size()), '0);
    check("frame_events_drained", DW'(fd_q.size()), '0);
    mon_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
